resize_frame_buffer: RTL
========================

RESIZE_FRAME_BUFFER -- requirements
Module: resize_frame_buffer

Interface
REQ-001 SHALL have parameter SIZE_X, default 64, output frame width in pixels.
REQ-002 SHALL have parameter SIZE_Y, default 64, output frame height in lines.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port vsync_in  input  1  frame sync from imresize; rising edge marks frame start.
REQ-006 SHALL have port de_in  input  1  pixel valid from imresize.
REQ-007 SHALL have port pixel_in  input  24  RGB pixel: [23:16]=R, [15:8]=G, [7:0]=B.
REQ-008 SHALL have port capture_req  input  1  one-cycle request to grab the next full frame.
REQ-009 SHALL have port m_valid  output  1  grayscale read-out data valid.
REQ-010 SHALL have port m_ready  input  1  downstream (CNN input) accepts data.
REQ-011 SHALL have port m_data  output  8  grayscale pixel, raster order.
REQ-012 SHALL have port m_last  output  1  high with final pixel (index SIZE_X*SIZE_Y-1).
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse on a short input frame.

Function
REQ-015 SHALL implement FSM states IDLE, ARMED, CAPTURE, DRAIN.
REQ-016 IDLE -> ARMED on capture_req=1; capture_req SHALL be ignored in all other states.
REQ-017 ARMED -> CAPTURE on a vsync_in rising edge (registered previous vsync_in=0, current=1); write address cleared to 0.
REQ-018 Gray conversion SHALL be (77*R + 150*G + 29*B) >> 8, 16-bit unsigned intermediate, no rounding; result 0..255.
REQ-019 Conversion SHALL be one register stage: pixel with de_in=1 at cycle N is written to RAM at cycle N+1.
REQ-020 In CAPTURE each registered valid pixel SHALL be written at wr_addr, then wr_addr increments; de_in=0 cycles write nothing.
REQ-021 CAPTURE -> DRAIN after write of address SIZE_X*SIZE_Y-1; further de_in pixels of that frame SHALL be ignored.
REQ-022 vsync_in rising edge in CAPTURE before the frame is complete SHALL pulse frame_err for one cycle and restart capture at address 0 (stay in CAPTURE).
REQ-023 DRAIN SHALL read RAM sequentially from address 0; RAM read latency is 1 cycle; first m_valid no later than 2 cycles after DRAIN entry.
REQ-024 Handshake: transfer occurs when m_valid=1 and m_ready=1; while m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
REQ-025 With m_ready held high, DRAIN SHALL sustain one pixel per cycle (no bubbles after the first).
REQ-026 After the m_last transfer, FSM SHALL return to IDLE next cycle with m_valid=0.
REQ-027 Input traffic (vsync_in, de_in) in IDLE, ARMED (other than the trigger edge) and DRAIN SHALL NOT modify RAM contents.

Reset
REQ-028 On rst_n=0 at a clock edge: state IDLE, wr/rd addresses 0, m_valid=0, m_last=0, m_data=0, busy=0, frame_err=0, vsync edge register 0.
REQ-029 Reset mid-CAPTURE or mid-DRAIN SHALL abandon the frame; no m_valid until a new capture_req completes a capture; RAM contents need not be cleared.

Structure
REQ-030 Shared package SHALL hold state encoding (IDLE=0, ARMED=1, CAPTURE=2, DRAIN=3), gray coefficients 77/150/29, and default frame size constants 64/64.
REQ-031 Storage SHALL be one sub-module, simple_dp_ram (8-bit wide, SIZE_X*SIZE_Y deep, one write port, one registered read port), inferable as block RAM.
REQ-032 Address width SHALL be clog2(SIZE_X*SIZE_Y) (12 bits at default).

Verification
REQ-033 Constant frame pixel_in=24'hFF0000 (64x64), capture_req before vsync -> 4096 beats m_data=8'd76, m_last only on beat 4096, then busy=0.
REQ-034 pixel_in=24'hFFFFFF -> all m_data=8'd255; pixel_in=24'h00FF00 -> all m_data=8'd149.
REQ-035 Ramp frame (R=G=B=index mod 256) with m_ready toggling 1,0,0,1 random pattern -> output sequence equals gray(index) in order, no loss/duplication, data stable during stalls.
REQ-036 vsync rising after 1000 pixels in CAPTURE -> frame_err pulses exactly one cycle; subsequent complete frame drained correctly (4096 beats).
REQ-037 No capture_req, three input frames -> m_valid stays 0, busy stays 0; capture_req during DRAIN -> ignored, no second drain.
REQ-038 rst_n=0 for one cycle at beat 2000 of DRAIN -> m_valid=0 next cycle, state IDLE; new capture_req + frame -> full 4096-beat drain.

Source files
------------

// File: rtl/resize_frame_buffer_pkg.sv
// Shared definitions for the resize frame buffer: FSM encoding, grayscale
// coefficients and default frame geometry.
package resize_frame_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam int unsigned GRAY_COEF_R = 77;
    localparam int unsigned GRAY_COEF_G = 150;
    localparam int unsigned GRAY_COEF_B = 29;

    localparam int unsigned DEFAULT_SIZE_X = 64;
    localparam int unsigned DEFAULT_SIZE_Y = 64;

    // Coefficients sum to 256, so the 16-bit sum cannot overflow and >>8 truncates.
    function automatic logic [7:0] rgb_to_gray(input logic [23:0] rgb);
        logic [15:0] acc;
        acc = 16'(GRAY_COEF_R * rgb[23:16])
            + 16'(GRAY_COEF_G * rgb[15:8])
            + 16'(GRAY_COEF_B * rgb[7:0]);
        return acc[15:8];
    endfunction

endpackage

// File: rtl/resize_frame_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port with
// read enable, written so synthesis maps it onto block RAM.
module simple_dp_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // No reset on the read register keeps it inside the RAM primitive.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/resize_frame_buffer.sv
// Captures one full RGB frame on request, stores it as 8-bit grayscale and
// streams it out in raster order over a valid/ready interface.
module resize_frame_buffer
    import resize_frame_buffer_pkg::*;
#(
    parameter int unsigned SIZE_X = DEFAULT_SIZE_X,
    parameter int unsigned SIZE_Y = DEFAULT_SIZE_Y
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync_in,
    input  logic        de_in,
    input  logic [23:0] pixel_in,
    input  logic        capture_req,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        busy,
    output logic        frame_err
);

    localparam int unsigned DEPTH  = SIZE_X * SIZE_Y;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t state;
    state_t state_nx;

    logic              vsync_q;
    logic              vsync_rise;
    logic              pix_de_q;
    logic [7:0]        pix_gray_q;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_done;
    logic              valid_q;
    logic              last_q;
    logic [7:0]        ram_rd_data;
    logic              wr_en;
    logic              rd_en;
    logic              xfer;

    assign vsync_rise = vsync_in & ~vsync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        xfer     = valid_q & m_ready;
        case (state)
            IDLE: begin
                if (capture_req) begin
                    state_nx = ARMED;
                end
            end
            ARMED: begin
                if (vsync_rise) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                // A pixel still in the register stage when a new frame starts belongs to the abandoned frame.
                if (!vsync_rise && pix_de_q) begin
                    wr_en = 1'b1;
                    if (wr_addr == LAST_ADDR) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Reading only when the output slot frees up keeps the RAM output register stable under stall.
                rd_en = !rd_done && (!valid_q || m_ready);
                if (xfer && last_q) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q    <= 1'b0;
            pix_de_q   <= 1'b0;
            pix_gray_q <= '0;
            frame_err  <= 1'b0;
            wr_addr    <= '0;
        end else begin
            vsync_q    <= vsync_in;
            pix_de_q   <= de_in;
            pix_gray_q <= rgb_to_gray(pixel_in);
            frame_err  <= (state == CAPTURE) && vsync_rise;
            if ((state == ARMED || state == CAPTURE) && vsync_rise) begin
                wr_addr <= '0;
            end else if (wr_en) begin
                wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr <= '0;
            rd_done <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (state != DRAIN) begin
                rd_addr <= '0;
                rd_done <= 1'b0;
            end else if (rd_en) begin
                rd_addr <= (rd_addr == LAST_ADDR) ? rd_addr : rd_addr + ADDR_W'(1);
                rd_done <= (rd_addr == LAST_ADDR);
            end

            if (rd_en) begin
                valid_q <= 1'b1;
                last_q  <= (rd_addr == LAST_ADDR);
            end else if (xfer || state != DRAIN) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    simple_dp_ram #(
        .DATA_W (8),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (pix_gray_q),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    // The RAM read register is not reset, so data is gated to zero while idle.
    assign m_valid = valid_q;
    assign m_last  = last_q;
    assign m_data  = valid_q ? ram_rd_data : '0;
    assign busy    = (state != IDLE);

endmodule
